// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared op/state encodings and default widths for the register bus master
package reg_bus_pkg;

  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_RESP
  } state_t;

endpackage

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-access register bus initiator with optional hardware poll (REG_BUS_MASTER_POLL_EN)
module reg_bus_master
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  input  logic [DATA_W-1:0]    cmd_mask,
  input  logic [TIMEOUT_W-1:0] cmd_limit,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 module_en,
  output logic                 wr,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    wdata,
  input  logic [DATA_W-1:0]    rdata
);

  state_t state;
  op_t    op_q;
  logic   cmd_illegal;

`ifdef REG_BUS_MASTER_POLL_EN
  logic [DATA_W-1:0]    expect_q;
  logic [DATA_W-1:0]    mask_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [TIMEOUT_W-1:0] attempts;
  logic [TIMEOUT_W-1:0] attempts_inc;
  logic                 poll_match;
  logic                 poll_done;

  // limit_q already holds max(limit,1), so reaching it ends the poll without wrapping
  assign attempts_inc = attempts + TIMEOUT_W'(1);
  assign poll_match   = ((rdata ^ expect_q) & mask_q) == '0;
  assign poll_done    = attempts_inc >= limit_q;
  assign cmd_illegal  = (cmd_op == OP_ILLEGAL);
`else
  logic unused_poll_inputs;

  assign unused_poll_inputs = ^{cmd_mask, cmd_limit};
  assign cmd_illegal        = (cmd_op == OP_ILLEGAL) || (cmd_op == OP_POLL);
`endif

  // Commands are only taken in IDLE; held low while reset is applied
  assign cmd_ready = (state == ST_IDLE) && !rst;

  // Control FSM; every bus and response output is a register set on the transition into its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= OP_WRITE;
      module_en <= 1'b0;
      wr        <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef REG_BUS_MASTER_POLL_EN
      expect_q  <= '0;
      mask_q    <= '0;
      limit_q   <= '0;
      attempts  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= op_t'(cmd_op);
            addr <= cmd_addr;
`ifdef REG_BUS_MASTER_POLL_EN
            expect_q <= cmd_wdata;
            mask_q   <= cmd_mask;
            limit_q  <= (cmd_limit == '0) ? TIMEOUT_W'(1) : cmd_limit;
            attempts <= '0;
`endif
            if (cmd_illegal) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state     <= ST_ACCESS;
              module_en <= 1'b1;
              wr        <= (cmd_op == OP_WRITE);
              wdata     <= (cmd_op == OP_WRITE) ? cmd_wdata : '0;
            end
          end
        end

        ST_ACCESS: begin
          module_en <= 1'b0;
          wr        <= 1'b0;
          wdata     <= '0;
          case (op_q)
            OP_WRITE: begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end
            OP_READ: begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata;
              rsp_err   <= 1'b0;
            end
`ifdef REG_BUS_MASTER_POLL_EN
            OP_POLL: begin
              attempts  <= attempts_inc;
              rsp_rdata <= rdata;
              if (poll_match) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
              end else if (poll_done) begin
                state     <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end else begin
                state <= ST_GAP;
              end
            end
`endif
            default: begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end
          endcase
        end

`ifdef REG_BUS_MASTER_POLL_EN
        ST_GAP: begin
          // one idle bus cycle so the slave's status flags can settle before the next read
          state     <= ST_ACCESS;
          module_en <= 1'b1;
          wr        <= 1'b0;
        end
`endif

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - scoreboard bench for reg_bus_master with a behavioural register slave
module tb_reg_bus_master;
  import reg_bus_pkg::*;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [DW-1:0] cmd_mask;
  logic [TW-1:0] cmd_limit;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          module_en;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  reg_bus_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_limit(cmd_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .module_en(module_en), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  int cyc = 0;
  int total = 0;
  int passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: 64 registers, reg 0x0A preset to 0xFF, reg 0x04 bit0 rises after its 3rd read
  logic [DW-1:0] regs [0:63];
  int poll_reads;
  assign rdata = regs[addr];

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 64; i++) regs[i] <= '0;
      regs[10]   <= 8'hFF;
      poll_reads <= 0;
    end else begin
      if (module_en && wr) regs[addr] <= wdata;
      if (module_en && !wr && addr == 6'h04) begin
        poll_reads <= poll_reads + 1;
        if (poll_reads == 2) regs[4] <= 8'h01;
      end
    end
  end

  typedef struct { int c; logic w; logic [AW-1:0] a; logic [DW-1:0] d; } bus_t;
  typedef struct { int c; logic [DW-1:0] rd; logic err; } rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t mb;
  rsp_t mr;
  int   first_cyc = -1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void push_bus(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus_q.push_back('{c: c, w: w, a: a, d: d});
  endfunction

  function automatic void push_rsp(input int c, input logic [DW-1:0] rd, input logic e);
    rsp_q.push_back('{c: c, rd: rd, err: e});
  endfunction

  // Bus monitor: every module_en cycle must match the next expected access
  always @(negedge clk) begin
    if (module_en) begin
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", {32'(cyc), addr}, 64'h0);
      end else begin
        mb = bus_q.pop_front();
        chk("bus_access", {32'(cyc), wr, addr, wdata}, {32'(mb.c), mb.w, mb.a, mb.d});
      end
    end
  end

  // Response monitor: first rsp_valid cycle, data and error checked at the handshake
  always @(negedge clk) begin
    if (!rsp_valid) begin
      first_cyc = -1;
    end else begin
      if (first_cyc < 0) first_cyc = cyc;
      if (rsp_ready) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", {32'(cyc), rsp_rdata}, 64'h0);
        end else begin
          mr = rsp_q.pop_front();
          chk("rsp", {32'(first_cyc), rsp_rdata, rsp_err}, {32'(mr.c), mr.rd, mr.err});
        end
        first_cyc = -1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command; returns n, the cycle whose closing edge takes the handshake
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m, input logic [TW-1:0] l, output int n);
    int budget = 0;
    cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_mask = m; cmd_limit = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && budget < 100) begin
      tick();
      budget++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'h0, 64'h1);
    n = cyc;
  endtask

  task automatic release_cmd();
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int budget = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0) && budget < 100) begin
      tick();
      budget++;
    end
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      chk("done_timeout", 64'(bus_q.size() + rsp_q.size()), 64'h0);
      bus_q.delete();
      rsp_q.delete();
    end
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    int n, n2;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
    cmd_mask = '0; cmd_limit = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, module_en, wr, addr, wdata}, 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    // write 0x5A to 0x09
    send(OP_WRITE, 6'h09, 8'h5A, 8'h00, 16'd0, n);
    push_bus(n + 1, 1'b1, 6'h09, 8'h5A);
    push_rsp(n + 2, 8'h00, 1'b0);
    release_cmd();
    wait_done();
    chk("slave_reg_09", regs[9], 8'h5A);

    // read 0x0A with the response held off for 5 cycles
    rsp_ready = 1'b0;
    send(OP_READ, 6'h0A, 8'h00, 8'h00, 16'd0, n);
    push_bus(n + 1, 1'b0, 6'h0A, 8'h00);
    push_rsp(n + 2, 8'hFF, 1'b0);
    release_cmd();
    while (cyc < n + 7) tick();
    chk("rsp_held", {rsp_valid, rsp_rdata, rsp_err}, {1'b1, 8'hFF, 1'b0});
    rsp_ready = 1'b1;
    wait_done();

    // back-to-back write then read-back at 3 cycles per command
    send(OP_WRITE, 6'h11, 8'hC3, 8'h00, 16'd0, n);
    push_bus(n + 1, 1'b1, 6'h11, 8'hC3);
    push_rsp(n + 2, 8'h00, 1'b0);
    release_cmd();
    send(OP_READ, 6'h11, 8'h00, 8'h00, 16'd0, n2);
    push_bus(n2 + 1, 1'b0, 6'h11, 8'h00);
    push_rsp(n2 + 2, 8'hC3, 1'b0);
    release_cmd();
    chk("b2b_spacing", 64'(n2 - n), 64'd3);
    wait_done();

    // illegal op: response next cycle, no bus access
    send(OP_ILLEGAL, 6'h0A, 8'h77, 8'h00, 16'd0, n);
    push_rsp(n + 1, 8'h00, 1'b1);
    release_cmd();
    wait_done();

`ifdef REG_BUS_MASTER_POLL_EN
    // poll bit0 of 0x04, set after the 3rd read: 4 reads
    send(OP_POLL, 6'h04, 8'h01, 8'h01, 16'd10, n);
    for (int k = 0; k < 4; k++) push_bus(n + 1 + 2 * k, 1'b0, 6'h04, 8'h00);
    push_rsp(n + 8, 8'h01, 1'b0);
    release_cmd();
    wait_done();

    // poll that never matches, limit 3
    send(OP_POLL, 6'h05, 8'h02, 8'h02, 16'd3, n);
    for (int k = 0; k < 3; k++) push_bus(n + 1 + 2 * k, 1'b0, 6'h05, 8'h00);
    push_rsp(n + 6, 8'h00, 1'b1);
    release_cmd();
    wait_done();

    // limit 0 behaves as a single attempt
    send(OP_POLL, 6'h05, 8'h02, 8'h02, 16'd0, n);
    push_bus(n + 1, 1'b0, 6'h05, 8'h00);
    push_rsp(n + 2, 8'h00, 1'b1);
    release_cmd();
    wait_done();

    // mask 0 matches on the first read
    send(OP_POLL, 6'h05, 8'h33, 8'h00, 16'd10, n);
    push_bus(n + 1, 1'b0, 6'h05, 8'h00);
    push_rsp(n + 2, 8'h00, 1'b0);
    release_cmd();
    wait_done();

    // reset while the poll sits in its gap cycle
    send(OP_POLL, 6'h06, 8'h80, 8'h80, 16'd10, n);
    push_bus(n + 1, 1'b0, 6'h06, 8'h00);
    release_cmd();
    tick();
    chk("gap_bus_idle", {module_en, rsp_valid}, 64'h0);
    rst = 1'b1;
    tick();
`else
    // poll op without the feature behaves as illegal
    send(OP_POLL, 6'h04, 8'h01, 8'h01, 16'd10, n);
    push_rsp(n + 1, 8'h00, 1'b1);
    release_cmd();
    wait_done();

    // reset while a read response is being held
    rsp_ready = 1'b0;
    send(OP_READ, 6'h0A, 8'h00, 8'h00, 16'd0, n);
    push_bus(n + 1, 1'b0, 6'h0A, 8'h00);
    release_cmd();
    tick();
    chk("resp_pending", rsp_valid, 1);
    rst = 1'b1;
    tick();
    rsp_ready = 1'b1;
`endif
    chk("mid_reset_outputs", {cmd_ready, rsp_valid, rsp_rdata, rsp_err, module_en, wr, addr, wdata}, 64'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_mid_reset", cmd_ready, 1);

    // fresh read after the reset
    send(OP_READ, 6'h0A, 8'h00, 8'h00, 16'd0, n);
    push_bus(n + 1, 1'b0, 6'h0A, 8'h00);
    push_rsp(n + 2, 8'hFF, 1'b0);
    release_cmd();
    wait_done();

    repeat (5) tick();
    chk("queues_drained", 64'(bus_q.size() + rsp_q.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
